// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   // Mul/div sequencing states
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_BUSY = 2'd1,
      MD_HOLD = 2'd2
   } mdState_t;

   // EX operand forwarding selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // ceil(log2(lat)), at least 1, for the mul/div occupancy counter
   function automatic int unsigned cntWidth(input int unsigned lat);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < lat) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/forward controls out.
// Optional perf-counter outputs are present only with HAZ_PERF_CNT_EN defined.
interface pipe_hazard_ctrl_if #(parameter int unsigned REG_AW = 5);
   logic [REG_AW-1:0] rs_d, rt_d;
   logic [REG_AW-1:0] rs_e, rt_e, rd_e;
   logic              reg_wr_e, mem_rd_e;
   logic [REG_AW-1:0] rd_m, rd_w;
   logic              reg_wr_m, reg_wr_w;
   logic              br_taken_e;
   logic              md_start_e;
   logic              mem_req_m;
   logic              dmem_ready;
   logic              stall_f, stall_d, stall_e, stall_m;
   logic              flush_d, flush_e, flush_m, flush_w;
   logic [1:0]        fwd_a_e, fwd_b_e;
   logic              md_done;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]       stall_cycles;
   logic [31:0]       flush_events;
`endif

   // Pipeline side
   modport master (
      output rs_d, rt_d, rs_e, rt_e, rd_e, reg_wr_e, mem_rd_e,
             rd_m, rd_w, reg_wr_m, reg_wr_w, br_taken_e, md_start_e,
             mem_req_m, dmem_ready,
      input  stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_m, flush_w,
             fwd_a_e, fwd_b_e, md_done
`ifdef HAZ_PERF_CNT_EN
      , input stall_cycles, flush_events
`endif
   );

   // Controller side
   modport slave (
      input  rs_d, rt_d, rs_e, rt_e, rd_e, reg_wr_e, mem_rd_e,
             rd_m, rd_w, reg_wr_m, reg_wr_w, br_taken_e, md_start_e,
             mem_req_m, dmem_ready,
      output stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_m, flush_w,
             fwd_a_e, fwd_b_e, md_done
`ifdef HAZ_PERF_CNT_EN
      , output stall_cycles, flush_events
`endif
   );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding select: MEM beats WB, register 0 never forwards.
module fwd_sel
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] rdM,
   input  logic              regWrM,
   input  logic [REG_AW-1:0] rdW,
   input  logic              regWrW,
   output logic [1:0]        sel
);

   // Priority compare against the in-flight destinations
   always_comb begin
      sel = FWD_RF;
      if (regWrM && (rdM != '0) && (rdM == src)) begin
         sel = FWD_MEM;
      end else if (regWrW && (rdW != '0) && (rdW == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stalls, flushes, EX forwarding,
// mul/div EX occupancy and data-memory wait handling.
// Optional: HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned MD_LAT = 4
) (
   input logic            clk,
   input logic            reset,
   pipe_hazard_ctrl_if.slave hz
);

   localparam int unsigned CNT_W = cntWidth(MD_LAT);

   mdState_t         state;
   logic [CNT_W-1:0] cnt;
   logic             memWait;
   logic             loadUse;
   logic             mdStall;
   logic             mdDone;
   logic             brEff;
   logic             luEff;
   logic [1:0]       fwdA;
   logic [1:0]       fwdB;

   fwd_sel #(.REG_AW(REG_AW)) uFwdA (
      .src(hz.rs_e), .rdM(hz.rd_m), .regWrM(hz.reg_wr_m),
      .rdW(hz.rd_w), .regWrW(hz.reg_wr_w), .sel(fwdA)
   );

   fwd_sel #(.REG_AW(REG_AW)) uFwdB (
      .src(hz.rt_e), .rdM(hz.rd_m), .regWrM(hz.reg_wr_m),
      .rdW(hz.rd_w), .regWrW(hz.reg_wr_w), .sel(fwdB)
   );

   // Raw hazard conditions
   always_comb begin
      memWait = hz.mem_req_m & ~hz.dmem_ready;
      loadUse = hz.mem_rd_e & hz.reg_wr_e & (hz.rd_e != '0) &
                ((hz.rd_e == hz.rs_d) | (hz.rd_e == hz.rt_d));
   end

   // Mul/div stall and completion decoded from the sequencer state
   always_comb begin
      mdStall = 1'b0;
      mdDone  = 1'b0;
      unique case (state)
         RUN:     mdStall = hz.md_start_e;
         MD_BUSY: begin
            if (cnt != '0) mdStall = 1'b1;
            else           mdDone  = ~memWait;
         end
         MD_HOLD: mdDone = ~memWait;
         default: ;
      endcase
   end

   // Mul/div sequencer; counter keeps running under a memory wait
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (hz.md_start_e) begin
                  cnt   <= CNT_W'(MD_LAT - 2);
                  state <= MD_BUSY;
               end
            end
            MD_BUSY: begin
               if (cnt != '0)    cnt   <= cnt - CNT_W'(1);
               else if (memWait) state <= MD_HOLD;
               else              state <= RUN;
            end
            MD_HOLD: begin
               if (!memWait) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // Branch kills a wrong-path load-use; both yield to mul/div and memory waits
   always_comb begin
      brEff = hz.br_taken_e & ~mdStall & ~memWait;
      luEff = loadUse & ~hz.br_taken_e & ~mdStall & ~memWait;
   end

   // Output drive; memory wait overrides all other stall/flush sources
   always_comb begin
      hz.stall_f = 1'b0;
      hz.stall_d = 1'b0;
      hz.stall_e = 1'b0;
      hz.stall_m = 1'b0;
      hz.flush_d = 1'b0;
      hz.flush_e = 1'b0;
      hz.flush_m = 1'b0;
      hz.flush_w = 1'b0;
      hz.fwd_a_e = FWD_RF;
      hz.fwd_b_e = FWD_RF;
      hz.md_done = 1'b0;
      if (!reset) begin
         hz.fwd_a_e = fwdA;
         hz.fwd_b_e = fwdB;
         hz.md_done = mdDone;
         if (memWait) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.stall_e = 1'b1;
            hz.stall_m = 1'b1;
            hz.flush_w = 1'b1;
         end else begin
            hz.stall_f = mdStall | luEff;
            hz.stall_d = mdStall | luEff;
            hz.stall_e = mdStall;
            hz.flush_d = brEff;
            hz.flush_e = brEff | luEff;
            hz.flush_m = mdStall;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stallCycles;
   logic [31:0] flushEvents;

   // Saturating perf counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCycles <= '0;
         flushEvents <= '0;
      end else begin
         if (hz.stall_f && (stallCycles != '1)) stallCycles <= stallCycles + 32'd1;
         if ((hz.flush_d || hz.flush_e) && (flushEvents != '1)) flushEvents <= flushEvents + 32'd1;
      end
   end

   assign hz.stall_cycles = stallCycles;
   assign hz.flush_events = flushEvents;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: reset, directed vector table, mul/div and
// memory-wait sequences, then randomized traffic against a reference model.
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT = 4;

   typedef struct {
      logic [4:0] rsD, rtD, rsE, rtE, rdE, rdM, rdW;
      logic regWrE, memRdE, regWrM, regWrW, br, mdStart, memReq, dmemReady, rst;
   } inVec_t;

   typedef struct {
      inVec_t      in;
      logic [12:0] exp;
      string       name;
   } vec_t;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

   pipe_hazard_ctrl #(.REG_AW(5), .MD_LAT(MD_LAT)) dut (
      .clk(clk), .reset(reset), .hz(hz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic inVec_t zv();
      inVec_t v;
      v.rsD = '0; v.rtD = '0; v.rsE = '0; v.rtE = '0; v.rdE = '0; v.rdM = '0; v.rdW = '0;
      v.regWrE = 0; v.memRdE = 0; v.regWrM = 0; v.regWrW = 0; v.br = 0;
      v.mdStart = 0; v.memReq = 0; v.dmemReady = 0; v.rst = 0;
      return v;
   endfunction

   task automatic apply(input inVec_t v);
      reset = v.rst;
      hz.rs_d = v.rsD; hz.rt_d = v.rtD; hz.rs_e = v.rsE; hz.rt_e = v.rtE;
      hz.rd_e = v.rdE; hz.rd_m = v.rdM; hz.rd_w = v.rdW;
      hz.reg_wr_e = v.regWrE; hz.mem_rd_e = v.memRdE;
      hz.reg_wr_m = v.regWrM; hz.reg_wr_w = v.regWrW;
      hz.br_taken_e = v.br; hz.md_start_e = v.mdStart;
      hz.mem_req_m = v.memReq; hz.dmem_ready = v.dmemReady;
   endtask

   // {stall f,d,e,m, flush d,e,m,w, fwd_a[1:0], fwd_b[1:0], md_done}
   function automatic logic [12:0] getOuts();
      return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
              hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w,
              hz.fwd_a_e, hz.fwd_b_e, hz.md_done};
   endfunction

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs and compare outputs mid-cycle
   task automatic cyc(input inVec_t v, input string name, input logic [12:0] exp);
      @(posedge clk); #1;
      apply(v);
      @(negedge clk);
      check(name, getOuts(), exp);
   endtask

   // Reference forwarding rule
   function automatic logic [1:0] fwdRef(input logic [4:0] src, input inVec_t v);
      if (v.regWrM && v.rdM != 0 && v.rdM == src) return 2'b10;
      if (v.regWrW && v.rdW != 0 && v.rdW == src) return 2'b01;
      return 2'b00;
   endfunction

   // Reference combinational outputs given mul/div stall/done for this cycle
   function automatic logic [12:0] modelOut(input inVec_t v, input logic mdStall, input logic mdDone);
      logic memWait, br, lu;
      logic [3:0] st, fl;
      memWait = v.memReq & ~v.dmemReady;
      st = 4'b0000; fl = 4'b0000;
      if (memWait) begin
         st = 4'b1111; fl = 4'b0001;
      end else begin
         br = v.br & ~mdStall;
         lu = v.memRdE & v.regWrE & (v.rdE != 0) & ((v.rdE == v.rsD) | (v.rdE == v.rtD))
              & ~v.br & ~mdStall;
         st = {mdStall | lu, mdStall | lu, mdStall, 1'b0};
         fl = {br, br | lu, mdStall, 1'b0};
      end
      return {st, fl, fwdRef(v.rsE, v), fwdRef(v.rtE, v), mdDone};
   endfunction

   initial begin
      vec_t        tab[$];
      vec_t        e;
      inVec_t      v, t;
      logic        mActive, mStall, mDone, finish, memWait;
      int          mAge;
      logic [12:0] exp;
      logic [31:0] pStall, pFlush;

      reset = 1'b1;
      apply(zv());
      v = zv(); v.rst = 1;
      cyc(v, "reset_idle", 13'b0);
      // Reset with every hazard source active must still force zeros
      v.rdM = 5; v.regWrM = 1; v.rsE = 5; v.memRdE = 1; v.regWrE = 1; v.rdE = 7; v.rtD = 7;
      v.memReq = 1; v.mdStart = 1; v.br = 1;
      cyc(v, "reset_busy_inputs", 13'b0);

      // Directed vector table (FSM idle in RUN)
      t = zv(); t.rdM = 5; t.regWrM = 1; t.rdW = 5; t.regWrW = 1; t.rsE = 5;
      e.in = t; e.exp = 13'b0000_0000_10_00_0; e.name = "fwd_mem_prio"; tab.push_back(e);
      t.rdM = 0;
      e.in = t; e.exp = 13'b0000_0000_01_00_0; e.name = "fwd_wb_rdm0"; tab.push_back(e);
      t.rdM = 5; t.rsE = 0;
      e.in = t; e.exp = 13'b0000_0000_00_00_0; e.name = "fwd_r0_never"; tab.push_back(e);
      t = zv(); t.rtE = 5; t.rdM = 5; t.rdW = 5; t.regWrW = 1;
      e.in = t; e.exp = 13'b0000_0000_00_01_0; e.name = "fwd_b_wb_memoff"; tab.push_back(e);
      t = zv(); t.memRdE = 1; t.regWrE = 1; t.rdE = 7; t.rtD = 7;
      e.in = t; e.exp = 13'b1100_0100_00_00_0; e.name = "load_use"; tab.push_back(e);
      t = zv(); t.rtD = 7; t.rdE = 7; t.regWrE = 1;
      e.in = t; e.exp = 13'b0; e.name = "after_load"; tab.push_back(e);
      t = zv(); t.memRdE = 1; t.regWrE = 1; t.rdE = 7; t.rtD = 7; t.br = 1;
      e.in = t; e.exp = 13'b0000_1100_00_00_0; e.name = "lu_plus_branch"; tab.push_back(e);
      t.memReq = 1; t.dmemReady = 0;
      e.in = t; e.exp = 13'b1111_0001_00_00_0; e.name = "mem_wait_override"; tab.push_back(e);
      t = zv(); t.memReq = 1; t.dmemReady = 1;
      e.in = t; e.exp = 13'b0; e.name = "mem_ready_nowait"; tab.push_back(e);
      t = zv(); t.memRdE = 1; t.regWrE = 1; t.rdE = 0; t.rsD = 0;
      e.in = t; e.exp = 13'b0; e.name = "load_r0_no_lu"; tab.push_back(e);
      t = zv(); t.memRdE = 1; t.regWrE = 1; t.rdE = 3; t.rsD = 3; t.rsE = 3; t.rdW = 3; t.regWrW = 1;
      e.in = t; e.exp = 13'b1100_0100_01_00_0; e.name = "lu_rs_with_fwd"; tab.push_back(e);
      foreach (tab[i]) cyc(tab[i].in, tab[i].name, tab[i].exp);

      // Mul/div with start held: MD_LAT-1 stall cycles then done
      v = zv(); v.mdStart = 1;
      for (int c = 0; c < MD_LAT - 1; c++) cyc(v, "md_stall", 13'b1110_0010_00_00_0);
      cyc(v, "md_done", 13'b0000_0000_00_00_1);
      cyc(zv(), "md_idle", 13'b0);

      // Mul/div with memory wait over cycles 2..6: done only once memory is ready
      v = zv(); v.mdStart = 1;
      cyc(v, "mdw_c0", 13'b1110_0010_00_00_0);
      cyc(zv(), "mdw_c1", 13'b1110_0010_00_00_0);
      v = zv(); v.memReq = 1;
      for (int c = 2; c <= 6; c++) cyc(v, "mdw_wait", 13'b1111_0001_00_00_0);
      v.dmemReady = 1;
      cyc(v, "mdw_done", 13'b0000_0000_00_00_1);
      cyc(zv(), "mdw_idle", 13'b0);

      // Reset while busy with cnt=1 aborts the op
      v = zv(); v.mdStart = 1;
      cyc(v, "mdr_c0", 13'b1110_0010_00_00_0);
      cyc(zv(), "mdr_c1", 13'b1110_0010_00_00_0);
      v = zv(); v.rst = 1;
      cyc(v, "mdr_reset", 13'b0);
      cyc(zv(), "mdr_after0", 13'b0);
`ifdef HAZ_PERF_CNT_EN
      check32("perf_stall_after_reset", hz.stall_cycles, 32'd0);
      check32("perf_flush_after_reset", hz.flush_events, 32'd0);
`endif
      for (int c = 0; c < MD_LAT; c++) cyc(zv(), "mdr_no_done", 13'b0);
      v = zv(); v.mdStart = 1;
      cyc(v, "mdr_restart_run", 13'b1110_0010_00_00_0);

      // Randomized traffic against the reference model
      v = zv(); v.rst = 1;
      cyc(v, "rand_reset", 13'b0);
      mActive = 0; mAge = 0; pStall = 0; pFlush = 0;
      for (int i = 0; i < 3000; i++) begin
         v.rsD = 5'($urandom_range(0, 3)); v.rtD = 5'($urandom_range(0, 3));
         v.rsE = 5'($urandom_range(0, 3)); v.rtE = 5'($urandom_range(0, 3));
         v.rdE = 5'($urandom_range(0, 3)); v.rdM = 5'($urandom_range(0, 3));
         v.rdW = 5'($urandom_range(0, 3));
         v.regWrE = 1'($urandom_range(0, 1)); v.memRdE = 1'($urandom_range(0, 1));
         v.regWrM = 1'($urandom_range(0, 1)); v.regWrW = 1'($urandom_range(0, 1));
         v.br = ($urandom_range(0, 5) == 0);
         v.mdStart = ($urandom_range(0, 7) == 0);
         v.memReq = ($urandom_range(0, 2) == 0);
         v.dmemReady = 1'($urandom_range(0, 1));
         v.rst = ($urandom_range(0, 99) == 0);

         // Mul/div occupancy measured as age since the op entered E
         memWait = v.memReq & ~v.dmemReady;
         mStall = 0; mDone = 0; finish = 0;
         if (!mActive) mStall = v.mdStart;
         else if (mAge < MD_LAT - 1) mStall = 1;
         else if (!memWait) begin mDone = 1; finish = 1; end
         exp = v.rst ? 13'b0 : modelOut(v, mStall, mDone);

         @(posedge clk); #1;
         apply(v);
         @(negedge clk);
         check("rand", getOuts(), exp);
`ifdef HAZ_PERF_CNT_EN
         check32("rand_perf_stall", hz.stall_cycles, pStall);
         check32("rand_perf_flush", hz.flush_events, pFlush);
`endif
         if (v.rst) begin
            mActive = 0; mAge = 0; pStall = 0; pFlush = 0;
         end else begin
            if (!mActive && v.mdStart) begin
               mActive = 1; mAge = 1;
            end else if (mActive) begin
               if (finish) mActive = 0;
               else mAge++;
            end
            if (exp[12] && pStall != 32'hFFFF_FFFF) pStall++;
            if ((exp[8] || exp[7]) && pFlush != 32'hFFFF_FFFF) pFlush++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
